// File: rtl/baby_pkg.sv
// Shared types and default geometry for the Baby RAM loader.
// Optional checksum output is enabled by defining BABY_LOADER_CHECKSUM_EN.
package baby_pkg;

  localparam int BABY_ADDR_W = 5;
  localparam int BABY_DATA_W = 32;
  localparam int BPW         = BABY_DATA_W / 8;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    LOAD    = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } loader_state_t;

  typedef logic [BABY_DATA_W-1:0] word_t;
  typedef logic [BABY_ADDR_W-1:0] addr_t;

endpackage

// File: rtl/baby_word_store.sv
// Main store: flop array cleared by reset, one synchronous write port and
// one combinational read port.
module baby_word_store #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clock_i,
  input  logic              reset_ni,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/baby_ram_loader.sv
// Baby core RAM plus byte-serial program loader; holds the core in reset
// until the store is loaded. Define BABY_LOADER_CHECKSUM_EN for checksum_o.
module baby_ram_loader
  import baby_pkg::*;
#(
  parameter int ADDR_W = BABY_ADDR_W,
  parameter int DATA_W = BABY_DATA_W
) (
  input  logic              clock_i,
  input  logic              reset_ni,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [DATA_W-1:0] core_data_i,
  input  logic              core_rw_en_i,
  output logic [DATA_W-1:0] core_data_o,
  output logic              core_reset_o,
  input  logic              run_i,
  input  logic              load_start_i,
  input  logic              load_valid_i,
  input  logic [7:0]        load_byte_i,
  output logic              load_ready_o,
  output logic              load_busy_o,
  output logic              load_done_o
`ifdef BABY_LOADER_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum_o
`endif
);

  localparam int LBPW = DATA_W / 8;
  localparam int BCW  = (LBPW > 1) ? $clog2(LBPW) : 1;
  localparam logic [BCW-1:0] LAST_LANE = BCW'(LBPW - 1);

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
  logic [BCW-1:0]    byte_cnt_q, byte_cnt_d;
  logic [DATA_W-1:0] asm_q, asm_d;
  logic [DATA_W-1:0] load_word;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
`ifdef BABY_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;
`endif

  // Final byte completes the word directly; it never lands in asm_q.
  always_comb begin
    load_word = asm_q;
    load_word[DATA_W-1 -: 8] = load_byte_i;
  end

  always_comb begin
    state_d    = state_q;
    addr_cnt_d = addr_cnt_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    we         = 1'b0;
    waddr      = core_addr_i;
    wdata      = core_data_i;
`ifdef BABY_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    case (state_q)
      HOLD: begin
        if (load_start_i) begin
          state_d = LOAD;
        end else if (run_i) begin
          state_d = RUN;
        end
      end
      LOAD: begin
        if (!load_start_i && load_valid_i) begin
          if (byte_cnt_q == LAST_LANE) begin
            we         = 1'b1;
            waddr      = addr_cnt_q;
            wdata      = load_word;
            byte_cnt_d = '0;
            addr_cnt_d = addr_cnt_q + 1'b1;
`ifdef BABY_LOADER_CHECKSUM_EN
            csum_d     = csum_q + load_word;
`endif
            if (addr_cnt_q == '1) state_d = RELEASE;
          end else begin
            asm_d[8*int'(byte_cnt_q) +: 8] = load_byte_i;
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
      end
      RELEASE: begin
        state_d = RUN;
      end
      RUN: begin
        if (load_start_i) begin
          state_d = LOAD;
        end else if (core_rw_en_i) begin
          we = 1'b1;
        end
      end
      default: state_d = HOLD;
    endcase
    // Any start accepted in HOLD/LOAD/RUN begins a fresh image at word 0.
    if (load_start_i && (state_q != RELEASE)) begin
      addr_cnt_d = '0;
      byte_cnt_d = '0;
      asm_d      = '0;
`ifdef BABY_LOADER_CHECKSUM_EN
      csum_d     = '0;
`endif
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= HOLD;
      addr_cnt_q <= '0;
      byte_cnt_q <= '0;
      asm_q      <= '0;
`ifdef BABY_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      addr_cnt_q <= addr_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
`ifdef BABY_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign core_reset_o = (state_q != RUN);
  assign load_ready_o = (state_q == LOAD);
  assign load_busy_o  = (state_q == LOAD);
  assign load_done_o  = (state_q == RELEASE);
`ifdef BABY_LOADER_CHECKSUM_EN
  assign checksum_o   = csum_q;
`endif

  baby_word_store #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_store (
    .clock_i  (clock_i),
    .reset_ni (reset_ni),
    .we_i     (we),
    .waddr_i  (waddr),
    .wdata_i  (wdata),
    .raddr_i  (core_addr_i),
    .rdata_o  (core_data_o)
  );

endmodule
